// File: rtl/udp_reg_master_mp_pkg.sv
// udp_reg_master_mp_pkg: shared state encodings, result defaults and source-range helper
package udp_reg_master_mp_pkg;

    typedef enum logic [1:0] {M_FREE, M_WAIT, M_DRAIN} mst_t;
    typedef enum logic [1:0] {P_IDLE, P_PEND, P_DONE} pst_t;

    localparam logic [31:0] TIMEOUT_RESULT_DEF = 32'hdead_0000;
    localparam logic [31:0] NACK_RESULT_DEF    = 32'hdead_beef;

    function automatic logic src_in_range(input int src, input int base, input int n);
        return (src >= base) && (src < base + n);
    endfunction

endpackage

// File: rtl/udp_reg_master_mp_rr_arbiter.sv
// udp_reg_rr_arbiter: round-robin grant over pending ports; pointer moves past the winner on advance
module udp_reg_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int IW = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IW-1:0]        gnt_idx
);

    logic [IW-1:0]          ptr;
    logic [2*NUM_PORTS-1:0] rot;
    logic                   found;
    int                     k;

    always_comb begin
        rot = {req, req} >> ptr;
        found = 1'b0;
        gnt_idx = '0;
        k = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                k = int'(ptr) + i;
                gnt_idx = IW'(k >= NUM_PORTS ? k - NUM_PORTS : k);
            end
        end
        gnt = found ? NUM_PORTS'(1) << gnt_idx : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else if (advance && found)
            ptr <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/udp_reg_master_mp.sv
// udp_reg_master_mp: arbitrates core register requesters onto one UDP register ring.
// Optional per-port error counters (err_cnt) when UDP_REG_MASTER_ERR_CNT_EN is defined.
module udp_reg_master_mp
    import udp_reg_master_mp_pkg::*;
#(
    parameter int          NUM_PORTS         = 2,
    parameter int          SRC_BASE          = 0,
    parameter int          UDP_REG_SRC_WIDTH = 3,
    parameter int          ADDR_WIDTH        = 23,
    parameter int          DATA_WIDTH        = 32,
    parameter int          TIMEOUT           = 127,
    parameter logic [31:0] TIMEOUT_RESULT    = TIMEOUT_RESULT_DEF,
    parameter logic [31:0] NACK_RESULT       = NACK_RESULT_DEF
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            core_reg_req,
    output logic [NUM_PORTS-1:0]            core_reg_ack,
    input  logic [NUM_PORTS-1:0]            core_reg_rd_wr_L,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] core_reg_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] core_reg_wr_data,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] core_reg_rd_data,
    output logic                            reg_req_out,
    output logic                            reg_ack_out,
    output logic                            reg_rd_wr_L_out,
    output logic [ADDR_WIDTH-1:0]           reg_addr_out,
    output logic [DATA_WIDTH-1:0]           reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out,
    input  logic                            reg_req_in,
    input  logic                            reg_ack_in,
    input  logic                            reg_rd_wr_L_in,
    input  logic [ADDR_WIDTH-1:0]           reg_addr_in,
    input  logic [DATA_WIDTH-1:0]           reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in
`ifdef UDP_REG_MASTER_ERR_CNT_EN
   ,output logic [NUM_PORTS*16-1:0]         err_cnt
`endif
);

    localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = UDP_REG_SRC_WIDTH;

    mst_t                  mst;
    pst_t                  pst [NUM_PORTS];
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         cur, gnt_idx;
    logic [NUM_PORTS-1:0]  cur_oh, gnt, pend;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  own, match, issue, to, abort, done;

    always_comb begin
        pend = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            pend[p] = pst[p] == P_PEND && core_reg_req[p];
    end

    assign own    = reg_req_in && src_in_range(int'(reg_src_in), SRC_BASE, NUM_PORTS);
    assign match  = own && mst != M_FREE && reg_src_in == SW'(SRC_BASE + int'(cur));
    assign issue  = mst == M_FREE && !reg_req_in && |pend;
    assign to     = mst != M_FREE && !match && cnt == '0;
    assign abort  = mst == M_WAIT && !(|(cur_oh & core_reg_req));
    assign done   = mst == M_WAIT && !abort && (match || cnt == '0);
    assign rd_val = match ? (reg_ack_in ? reg_data_in : DATA_WIDTH'(NACK_RESULT))
                          : DATA_WIDTH'(TIMEOUT_RESULT);

    udp_reg_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IW(IW)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (pend),
        .advance (issue),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // An aborted transaction keeps the ring busy (DRAIN) until its response or timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mst    <= M_FREE;
            cnt    <= '0;
            cur    <= '0;
            cur_oh <= '0;
        end else if (issue) begin
            mst    <= M_WAIT;
            cnt    <= CW'(TIMEOUT);
            cur    <= gnt_idx;
            cur_oh <= gnt;
        end else if (mst != M_FREE) begin
            if (match || cnt == '0) begin
                mst <= M_FREE;
            end else begin
                mst <= abort ? M_DRAIN : mst;
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PORTS; p++)
                pst[p] <= P_IDLE;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++)
                case (pst[p])
                    P_IDLE:  if (core_reg_req[p]) pst[p] <= P_PEND;
                    P_PEND:  if (!core_reg_req[p]) pst[p] <= P_IDLE;
                             else if (done && cur_oh[p]) pst[p] <= P_DONE;
                    P_DONE:  if (!core_reg_req[p]) pst[p] <= P_IDLE;
                    default: pst[p] <= P_IDLE;
                endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_reg_ack     <= '0;
            core_reg_rd_data <= '0;
        end else begin
            core_reg_ack <= done ? cur_oh : '0;
            for (int p = 0; p < NUM_PORTS; p++)
                if (done && cur_oh[p])
                    core_reg_rd_data[p*DATA_WIDTH +: DATA_WIDTH] <= rd_val;
        end
    end

    // Foreign traffic passes through; own responses are consumed and leave the ring idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {reg_req_out, reg_ack_out, reg_rd_wr_L_out} <= '0;
            reg_addr_out <= '0;
            reg_data_out <= '0;
            reg_src_out  <= '0;
        end else if (reg_req_in && !own) begin
            {reg_req_out, reg_ack_out, reg_rd_wr_L_out} <= {1'b1, reg_ack_in, reg_rd_wr_L_in};
            reg_addr_out <= reg_addr_in;
            reg_data_out <= reg_data_in;
            reg_src_out  <= reg_src_in;
        end else if (issue) begin
            {reg_req_out, reg_ack_out, reg_rd_wr_L_out} <= {2'b10, core_reg_rd_wr_L[gnt_idx]};
            reg_addr_out <= core_reg_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            reg_data_out <= core_reg_wr_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            reg_src_out  <= SW'(SRC_BASE + int'(gnt_idx));
        end else begin
            {reg_req_out, reg_ack_out, reg_rd_wr_L_out} <= '0;
            reg_addr_out <= '0;
            reg_data_out <= '0;
            reg_src_out  <= '0;
        end
    end

`ifdef UDP_REG_MASTER_ERR_CNT_EN
    logic err_evt;

    assign err_evt = to || (done && match && !reg_ack_in);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_cnt <= '0;
        else
            for (int p = 0; p < NUM_PORTS; p++)
                if (err_evt && cur_oh[p] && err_cnt[p*16 +: 16] != 16'hffff)
                    err_cnt[p*16 +: 16] <= err_cnt[p*16 +: 16] + 16'd1;
    end
`endif

endmodule
